// File: rtl/thumb_pipe_pkg.sv
// Shared types for the Thumb pipeline controller: fetch states, stall causes,
// and the stall-priority resolver used by the controller and trace logic.
package thumb_pipe_pkg;

  typedef enum logic [2:0] {
    F_REQ  = 3'd0,
    F_WAIT = 3'd1,
    F_LO   = 3'd2,
    F_HI   = 3'd3,
    F_DROP = 3'd4
  } fstate_t;

  typedef enum logic [2:0] {
    SC_NONE  = 3'd0,
    SC_DM    = 3'd1,
    SC_BR    = 3'd2,
    SC_LDUSE = 3'd3,
    SC_FETCH = 3'd4
  } stall_cause_t;

  // Highest-priority reason the pipeline cannot flow freely this cycle.
  function automatic stall_cause_t stall_cause(input logic dm_wait, input logic br,
                                               input logic lduse, input logic fvld);
    if (dm_wait)    return SC_DM;
    else if (br)    return SC_BR;
    else if (lduse) return SC_LDUSE;
    else if (!fvld) return SC_FETCH;
    else            return SC_NONE;
  endfunction

endpackage

// File: rtl/thumb_fetch_seq.sv
// Fetch sequencer: requests one 32-bit word, then presents its two halfwords
// (or only the upper one after a branch to an odd-halfword target).
module thumb_fetch_seq
  import thumb_pipe_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic im_ack_i,
  input  logic br_i,        // taken branch, already suppressed while MEM is frozen
  input  logic br_tgt_hi_i,
  input  logic pc_en_i,
  input  logic freeze_i,    // MEM data wait: hold, but still accept word responses
  output logic im_req_o,
  output logic im_latch_o,
  output logic half_sel_o,
  output logic fvld_o
);

  fstate_t state_q, state_d;
  logic    start_hi_q, start_hi_d;

  // State and start-halfword registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= F_REQ;
      start_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_hi_q <= start_hi_d;
    end
  end

  // Next state and strobes; a branch redirects from any state.
  always_comb begin
    state_d    = state_q;
    start_hi_d = start_hi_q;
    im_req_o   = 1'b0;
    im_latch_o = 1'b0;
    if (br_i) begin
      start_hi_d = br_tgt_hi_i;
      // A word still in flight must be absorbed before re-requesting.
      state_d    = (state_q == F_WAIT && !im_ack_i) ? F_DROP : F_REQ;
    end else begin
      case (state_q)
        F_REQ:  if (!freeze_i) begin
                  im_req_o = 1'b1;
                  state_d  = F_WAIT;
                end
        F_WAIT: if (im_ack_i) begin
                  im_latch_o = 1'b1;
                  state_d    = start_hi_q ? F_HI : F_LO;
                  start_hi_d = 1'b0;
                end
        F_LO:   if (pc_en_i) state_d = F_HI;
        F_HI:   if (pc_en_i) state_d = F_REQ;
        F_DROP: if (im_ack_i) state_d = F_REQ;
        default: state_d = F_REQ;
      endcase
    end
  end

  assign half_sel_o = (state_q == F_HI);
  assign fvld_o     = (state_q == F_LO) || (state_q == F_HI);

endmodule

// File: rtl/thumb_pipe_ctrl.sv
// Stall/flush controller for the 5-stage Thumb pipeline. Resolves memory wait,
// taken branch, load-use and fetch starvation into register enables, and
// counts cycles in which the PC does not advance.
module thumb_pipe_ctrl
  import thumb_pipe_pkg::*;
#(
  parameter int PERF_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              HZ_LDUSE_i,
  input  logic              BR_TAKEN_i,
  input  logic              BR_TGT_HI_i,
  input  logic              IM_ACK_i,
  input  logic              DM_ACC_i,
  input  logic              DM_ACK_i,
  output logic              IM_REQ_o,
  output logic              IM_LATCH_o,
  output logic              HALF_SEL_o,
  output logic              PC_EN_o,
  output logic              IF_ID_EN_o,
  output logic              IF_ID_FLUSH_o,
  output logic              ID_EX_EN_o,
  output logic              ID_EX_BUBBLE_o,
  output logic              EX_MEM_EN_o,
  output logic              MEM_WB_EN_o,
  output logic [PERF_W-1:0] STALL_CYC_o
);

  logic dm_wait, br_eff, fvld;
  logic im_req, im_latch, half_sel;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
  logic [PERF_W-1:0] stall_q, stall_d;
  stall_cause_t cause;

  assign dm_wait = DM_ACC_i & ~DM_ACK_i;
  // EX is frozen during a data wait, so the branch is acted on once it clears.
  assign br_eff  = BR_TAKEN_i & ~dm_wait;
  assign cause   = stall_cause(dm_wait, BR_TAKEN_i, HZ_LDUSE_i, fvld);

  thumb_fetch_seq u_fetch (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .im_ack_i    (IM_ACK_i),
    .br_i        (br_eff),
    .br_tgt_hi_i (BR_TGT_HI_i),
    .pc_en_i     (pc_en),
    .freeze_i    (dm_wait),
    .im_req_o    (im_req),
    .im_latch_o  (im_latch),
    .half_sel_o  (half_sel),
    .fvld_o      (fvld)
  );

  // Priority mux from stall cause to pipeline enables/flushes.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    case (cause)
      SC_DM: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
      SC_BR: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      SC_LDUSE: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
      SC_FETCH: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating count of cycles where the PC holds.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en && stall_q != {PERF_W{1'b1}}) stall_d = stall_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  // All outputs read as zero while reset is held.
  assign IM_REQ_o       = RESET_N & im_req;
  assign IM_LATCH_o     = RESET_N & im_latch;
  assign HALF_SEL_o     = RESET_N & half_sel;
  assign PC_EN_o        = RESET_N & pc_en;
  assign IF_ID_EN_o     = RESET_N & if_id_en;
  assign IF_ID_FLUSH_o  = RESET_N & if_id_flush;
  assign ID_EX_EN_o     = RESET_N & id_ex_en;
  assign ID_EX_BUBBLE_o = RESET_N & id_ex_bubble;
  assign EX_MEM_EN_o    = RESET_N & ex_mem_en;
  assign MEM_WB_EN_o    = RESET_N & mem_wb_en;
  assign STALL_CYC_o    = RESET_N ? stall_q : '0;

endmodule
